fan_tach_monitor: RTL

Reads the open-collector tach output of the 4-pin PWM cooler and returns measured RPM plus a stall flag, closing the loop on the speed command issued by the temperature-target controller. Synchronises and debounces tach, counts falling edges over a fixed gate window and converts the count to RPM. A supervision FSM uses speed_cmd to flag a fan that is commanded to spin but produces no tach edges.

---
 rtl/fan_pkg.sv | 19 +
 rtl/fan_tach_filter.sv | 37 +++
 rtl/fan_tach_monitor.sv | 81 ++++++++
 3 files changed

// File: rtl/fan_pkg.sv
// fan_pkg: shared state encodings, widths and default timing for the fan tach monitor
package fan_pkg;
  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_SPINUP = 2'd1,
    S_RUN    = 2'd2,
    S_STALL  = 2'd3
  } state_e;
  localparam int SPEED_W = 12;
  localparam int RPM_W = 16;
  localparam int PULSE_W = 12;
  localparam int PROD_W = 20;
  localparam int GATE_CYCLES_D = 50000000;
  localparam int RPM_MUL_D = 30;
  localparam int DEB_CYCLES_D = 500;
  localparam int STALL_CYCLES_D = 25000000;
  localparam int SPINUP_CYCLES_D = 100000000;
  localparam int MIN_SPIN_D = 20;
endpackage

// File: rtl/fan_tach_filter.sv
// fan_tach_filter: tach synchroniser, level debounce and falling-edge strobe
module fan_tach_filter
  import fan_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_D
) (
  input  logic clk,
  input  logic rst,
  input  logic tach_in,
  output logic tach_edge,
  output logic filt
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_END = DW'(DEB_CYCLES - 1);
  logic s1, s2, filt_d;
  logic [DW-1:0] deb_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      filt <= 1'b1;
      filt_d <= 1'b1;
      deb_cnt <= '0;
      tach_edge <= 1'b0;
    end else begin
      s1 <= tach_in;
      s2 <= s1;
      filt_d <= filt;
      tach_edge <= filt_d & ~filt;
      if (s2 == filt) deb_cnt <= '0;
      else if (deb_cnt == DEB_END) begin
        filt <= s2;
        deb_cnt <= '0;
      end else deb_cnt <= deb_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fan_tach_monitor.sv
// fan_tach_monitor: gated tach edge counter to RPM with commanded-speed stall supervision
module fan_tach_monitor
  import fan_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_D,
  parameter int RPM_MUL = RPM_MUL_D,
  parameter int DEB_CYCLES = DEB_CYCLES_D,
  parameter int STALL_CYCLES = STALL_CYCLES_D,
  parameter int SPINUP_CYCLES = SPINUP_CYCLES_D,
  parameter int MIN_SPIN = MIN_SPIN_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tach_in,
  input  logic [SPEED_W-1:0] speed_cmd,
  output logic [RPM_W-1:0]   rpm,
  output logic               rpm_valid,
  output logic               stall,
  output logic               tach_edge
);
  logic [31:0] gate_cnt, tmr, tmr_n;
  logic [PULSE_W-1:0] pulse_cnt, pulse_n;
  logic [PROD_W-1:0] prod;
  logic term, spd_ok;
  state_e state, state_n;
  fan_tach_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filter (
    .clk(clk),
    .rst(rst),
    .tach_in(tach_in),
    .tach_edge(tach_edge),
    .filt()
  );
  assign term = gate_cnt == 32'(GATE_CYCLES - 1);
  assign pulse_n = (tach_edge && pulse_cnt != '1) ? pulse_cnt + 1'b1 : pulse_cnt;
  assign prod = PROD_W'(pulse_n) * PROD_W'(RPM_MUL);
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt <= '0;
      pulse_cnt <= '0;
      rpm <= '0;
      rpm_valid <= 1'b0;
    end else begin
      gate_cnt <= term ? '0 : gate_cnt + 1'b1;
      pulse_cnt <= term ? '0 : pulse_n;
      rpm_valid <= term;
      if (term) rpm <= (prod > PROD_W'(20'hFFFF)) ? '1 : prod[RPM_W-1:0];
    end
  end
  // speed_cmd above 100 only matters through this threshold, so no clamp is needed
  assign spd_ok = speed_cmd >= SPEED_W'(MIN_SPIN);
  always_comb begin
    state_n = state;
    tmr_n = tmr + 1'b1;
    if (!spd_ok) begin
      state_n = S_OFF;
      tmr_n = '0;
    end else if (state == S_OFF) begin
      state_n = S_SPINUP;
      tmr_n = '0;
    end else if (tach_edge) begin
      state_n = S_RUN;
      tmr_n = '0;
    end else if (state == S_SPINUP && tmr == 32'(SPINUP_CYCLES - 1)) begin
      state_n = S_RUN;
      tmr_n = '0;
    end else if (state == S_RUN && tmr == 32'(STALL_CYCLES - 1)) begin
      state_n = S_STALL;
      tmr_n = '0;
    end else if (state == S_STALL) tmr_n = tmr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_OFF;
      tmr <= '0;
    end else begin
      state <= state_n;
      tmr <= tmr_n;
    end
  end
  assign stall = state == S_STALL;
endmodule
